decodificador_param: RTL
========================

# decodificador_param

Registered, parametrised successor to the team's combinational one-hot decoder: an N-bit code selects one of 2^N outputs, MSB-first (code 0 drives the top output bit). It adds a free-running scan mode that steps the active output automatically, for display-digit and row multiplexing. It also adds enable and load controls and a wrap indication. It sits between control logic and multiplexed output drivers, in the same clock domain as its controller.

## Interface
- N, 3, code width; 1..6; output width is 2^N
- DIV, 4, scan dwell in clock cycles per position; >= 1
- LAST, 2^N-1, highest code visited in scan mode; 0..2^N-1
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  block enable; 0 forces IDLE and blank outputs
- mode  input  1  0 = direct (code from in), 1 = scan (internal counter)
- load  input  1  direct mode: capture in into the index register
- in  input  N  code to decode in direct mode
- out  output  2^N  registered one-hot; bit (2^N-1-idx) set when active, else all 0
- idx  output  N  currently selected code
- wrap  output  1  one-cycle pulse when scan returns from LAST to 0

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, DIRECT, SCAN. rst -> IDLE, idx=0, dwell=0, out=0, wrap=0.
- Priority each edge: rst > en=0 > mode/load.
- Any state, en=0: next state IDLE, out=0, idx holds, wrap=0.
- IDLE, en=1, mode=0: on load go to DIRECT with idx=in. Without load, stay in IDLE.
- IDLE, en=1, mode=1: go to SCAN with idx=0, dwell=0.
- DIRECT: load=1 sets idx=in. Values above LAST are accepted, because LAST limits scan only. mode=1 -> SCAN with idx=0 and dwell=0, a restart.
- SCAN: dwell counts 0..DIV-1. When dwell=DIV-1, dwell returns to 0 and idx advances:
  - idx<LAST: idx increments.
  - idx=LAST: idx goes to 0 and wrap is asserted for exactly that one cycle.
- SCAN, mode=0: go to DIRECT holding the current idx. If load=1 in the same cycle, idx=in instead.
- load is ignored in SCAN and in IDLE when mode=1.
- out = onehot(idx) in DIRECT and SCAN, 0 in IDLE. out, idx and wrap all update together on the same edge.
- LAST=0: scan stays on code 0, and wrap pulses once every DIV cycles.

## Timing
- Latency: one cycle. Inputs sampled at edge t appear on out/idx after edge t.
- Scan entry at edge t0 (N=3): out=8'b1000_0000 after t0, and 8'b0100_0000 after t0+DIV.
- Each scan position is held for exactly DIV cycles.
- Full period is (LAST+1)*DIV cycles. wrap has the same period, is high for 1 cycle and is coincident with idx=0.
- DIV=1: idx advances every cycle.
- Reset mid-scan: the next edge gives out=0 and idx=0. The scan restarts at code 0 on re-entry.
- en deasserted mid-scan then reasserted with mode=1: the scan restarts at idx=0 and does not resume.
- No combinational path from inputs to outputs.

## Configuration
- DECODIFICADOR_ACTIVE_LOW_EN defined: out is inverted at the register, for common-anode drivers.
  - Active position drives 0, all others 1.
  - IDLE and reset value is all ones.
  - idx and wrap are unaffected.
- Undefined: active-high as described above, and the reset value is all zeros.

## Test plan
- Reset and direct decode:
  - rst=1 for 2 cycles: out=0, idx=0, wrap=0.
  - Then en=1, mode=0, load=1, in=3'b101: out=8'b0000_0100 one cycle later.
  - Sweep in=0..7: out=8'b1000_0000..8'b0000_0001.
- Scan timing, DIV=4 and LAST=7:
  - mode=1: each bit is held 4 cycles, from 8'b1000_0000 down to 8'b0000_0001.
  - wrap is high for 1 cycle every 32 cycles, coincident with idx=0.
- Truncated scan, LAST=2 and DIV=1:
  - idx sequence 0,1,2,0,1,...
  - wrap high every 3rd cycle.
  - out never reaches 8'b0001_0000.
- Mode switches:
  - Scan at idx=5, then mode=0 with load=0: idx stays at 5 and out=8'b0000_0100.
  - Repeat with load=1 and in=1: out=8'b0100_0000.
  - mode=1 again: restart at idx=0.
- Enable and reset precedence:
  - en=0 with load=1: out=0 next cycle.
  - rst=1 together with en=1 and mode=1: IDLE, out=0.
  - Reset mid-dwell at idx=4: out=0 next cycle, and the scan restarts at code 0 on re-entry.
- Macro build:
  - With DECODIFICADOR_ACTIVE_LOW_EN defined, the reset value is 8'hFF.
  - in=3'b000 loaded gives out=8'b0111_1111.

Source files
------------

// File: rtl/decodificador_param.sv
// decodificador_param: registered, parametrised one-hot decoder with a free-running scan mode.
//
// An N-bit index selects one of 2^N outputs, MSB-first: index 0 drives the top output bit.
// There are three operating states:
//   IDLE   - outputs are blank.
//   DIRECT - the index is loaded from `in`.
//   SCAN   - the index steps through 0..LAST and dwells DIV cycles on each position.
// `wrap` pulses for one cycle when the scan returns from LAST to 0.
// The out, idx and wrap registers all update on the same edge, and no input reaches an
// output combinationally.
//
// Optional build macro: DECODIFICADOR_ACTIVE_LOW_EN.
//   When defined, `out` is inverted at the register for common-anode drivers. The active
//   position drives 0, and the IDLE/reset value is all ones. idx and wrap are unchanged.

module decodificador_param #(
    parameter int N    = 3,
    parameter int DIV  = 4,
    parameter int LAST = (1 << N) - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                load,
    input  logic [N-1:0]        in,
    output logic [(1<<N)-1:0]   out,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int W  = 1 << N;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DWELL_END = DW'(DIV - 1);
    localparam logic [N-1:0]  IDX_LAST  = N'(LAST);

`ifdef DECODIFICADOR_ACTIVE_LOW_EN
    localparam logic [W-1:0]  OUT_BLANK = {W{1'b1}};
`else
    localparam logic [W-1:0]  OUT_BLANK = {W{1'b0}};
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_p0, state_nxt;
    logic [N-1:0]    idx_p0,   idx_nxt;
    logic [DW-1:0]   dwell_p0, dwell_nxt;
    logic [W-1:0]    out_p0,   out_nxt;
    logic            wrap_p0,  wrap_nxt;

    // MSB-first one-hot: index 0 selects bit W-1, and the output polarity follows the build.
    function automatic logic [W-1:0] decode(input logic [N-1:0] code);
        logic [W-1:0] hot;
        hot = {1'b1, {(W-1){1'b0}}} >> code;
`ifdef DECODIFICADOR_ACTIVE_LOW_EN
        return ~hot;
`else
        return hot;
`endif
    endfunction

    // Scan successor: advance the index, falling back to 0 after LAST (or anything beyond it).
    function automatic logic [N-1:0] scan_next(input logic [N-1:0] code);
        if (code >= IDX_LAST) begin
            return '0;
        end
        return code + 1'b1;
    endfunction

    // State, index, dwell counter and output registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            idx_p0   <= '0;
            dwell_p0 <= '0;
            out_p0   <= OUT_BLANK;
            wrap_p0  <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            idx_p0   <= idx_nxt;
            dwell_p0 <= dwell_nxt;
            out_p0   <= out_nxt;
            wrap_p0  <= wrap_nxt;
        end
    end

    // Next-state logic: en=0 overrides everything, then mode/load act according to the state.
    always_comb begin
        state_nxt = state_p0;
        idx_nxt   = idx_p0;
        dwell_nxt = dwell_p0;
        wrap_nxt  = 1'b0;

        if (!en) begin
            // The index is kept; a later scan entry restarts from 0 anyway.
            state_nxt = IDLE;
            dwell_nxt = '0;
        end else begin
            unique case (state_p0)
                IDLE: begin
                    if (mode) begin
                        state_nxt = SCAN;
                        idx_nxt   = '0;
                        dwell_nxt = '0;
                    end else if (load) begin
                        state_nxt = DIRECT;
                        idx_nxt   = in;
                    end
                end

                DIRECT: begin
                    // Codes above LAST are legal here; LAST bounds only the scan.
                    if (mode) begin
                        state_nxt = SCAN;
                        idx_nxt   = '0;
                        dwell_nxt = '0;
                    end else if (load) begin
                        idx_nxt   = in;
                    end
                end

                SCAN: begin
                    if (!mode) begin
                        state_nxt = DIRECT;
                        dwell_nxt = '0;
                        if (load) begin
                            idx_nxt = in;
                        end
                    end else if (dwell_p0 == DWELL_END) begin
                        dwell_nxt = '0;
                        idx_nxt   = scan_next(idx_p0);
                        wrap_nxt  = (idx_p0 >= IDX_LAST);
                    end else begin
                        dwell_nxt = dwell_p0 + 1'b1;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    dwell_nxt = '0;
                end
            endcase
        end
    end

    // The output is decoded from the next index so that out, idx and wrap move together.
    always_comb begin
        out_nxt = OUT_BLANK;
        if (state_nxt != IDLE) begin
            out_nxt = decode(idx_nxt);
        end
    end

    assign out  = out_p0;
    assign idx  = idx_p0;
    assign wrap = wrap_p0;

endmodule
